// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Purpose:
//   Bundles the two ready/valid handshakes around one pipeline stage
//   register: the upstream side (in_*) and the downstream side (out_*).
//
// Parameters:
//   DATA_W     payload width in bits
//
// Signals:
//   in_valid   upstream has a payload
//   in_data    upstream payload
//   in_ready   stage can accept (registered inside the stage)
//   out_valid  stage presents a payload downstream
//   out_data   presented payload, or the bubble value when out_valid=0
//   out_ready  downstream accepts
//
// Modports:
//   slave      the stage register itself
//   master     the surrounding pipeline (producer and consumer stages)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface : pipe_stage_reg_if

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Parametrised ready/valid pipeline stage register with a 2-entry skid
//   buffer, hazard stall and flush. Carries any inter-stage payload
//   (PC+4, instruction, control bundle) as one DATA_W vector.
//   in_ready is fully registered, so no combinational ready path crosses
//   the stage boundary; the skid entry absorbs the beat that arrives while
//   the registered ready is catching up with a downstream stall.
//
// Parameters:
//   DATA_W      payload width in bits
//   BUBBLE_VAL  value driven on out_data while out_valid=0 (NOP encoding)
//   CNT_W       width of the statistics counters
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Reset_n     asynchronous active-low reset
//   bus         handshake bundle (slave modport): in_valid/in_data/in_ready
//               upstream, out_valid/out_data/out_ready downstream
//   Stall       hazard hold, freezes downstream transfer
//   Flush       kills all held payloads, highest priority
//   stall_cnt   saturating count of cycles with Stall=1
//   flush_cnt   saturating count of cycles with Flush=1
//
// Configuration:
//   PIPE_STAGE_STATS_EN  when defined, stall_cnt/flush_cnt are live
//                        saturating counters; when undefined they are tied
//                        to zero and the ports remain for interface parity.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    pipe_stage_reg_if.slave  bus,
    input  logic             Stall,
    input  logic             Flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Occupancy of the stage. SKID means both the main (output) entry and
    // the skid entry hold payloads; the main entry is always the older one.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_e;

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;

    logic accept;
    logic drain;

    // Upstream transfer uses the registered ready; a downstream transfer is
    // blocked by a stall even if the consumer is ready.
    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready & ~Stall;

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (Flush) begin
            // Flush wins over stall and over a same-cycle accept.
            state_d     = ST_EMPTY;
            main_data_d = BUBBLE_VAL;
            skid_data_d = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_data_d = bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_data_d = bus.in_data;
                    end else if (drain) begin
                        state_d     = ST_EMPTY;
                        main_data_d = BUBBLE_VAL;
                    end else if (accept) begin
                        // Downstream is not taking the main entry (not
                        // ready or stalled): park the new beat behind it.
                        state_d     = ST_SKID;
                        skid_data_d = bus.in_data;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        skid_data_d = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = BUBBLE_VAL;
                    skid_data_d = BUBBLE_VAL;
                end
            endcase
        end

        // Outputs are computed from the next state so they can be
        // registered; out_data is main_data_q directly because the main
        // entry is forced to BUBBLE_VAL whenever it becomes invalid.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID) & ~Stall;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_EMPTY;
            // NOTE: the payload registers are reset too, because out_data
            // must show BUBBLE_VAL immediately on reset rather than whatever
            // stale payload was in flight.
            main_data_q <= BUBBLE_VAL;
            skid_data_q <= BUBBLE_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data_q;

    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturate at all-ones instead of wrapping; only reset clears them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (Flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    // The skid entry is never offered a new beat.
    a_skid_not_ready : assert property (
        @(posedge Clk) disable iff (!Reset_n)
        (state_q == ST_SKID) |-> !in_ready_q
    );

    // An invalid output always shows the bubble encoding.
    a_bubble_when_idle : assert property (
        @(posedge Clk) disable iff (!Reset_n)
        !out_valid_q |-> (main_data_q == BUBBLE_VAL)
    );

    // out_valid mirrors occupancy.
    a_valid_tracks_state : assert property (
        @(posedge Clk) disable iff (!Reset_n)
        out_valid_q == (state_q != ST_EMPTY)
    );
`endif

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised ready/valid pipeline stage register with a 2-entry skid buffer, hazard stall and flush.
- Generic successor to the fixed two-field IF/ID latch; any inter-stage payload (PC+4, instruction, control bundle) is carried as one DATA_W vector.
- Sits between adjacent pipeline stages (IF/ID, ID/EX, ...).
- Fully registered in_ready, so there is no combinational ready path across stages.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {PC+4, Instr}).
- BUBBLE_VAL, 0, value driven on out_data whenever out_valid=0 (NOP encoding).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  stage holds a payload for downstream.
- out_data  out  DATA_W  payload, or BUBBLE_VAL when out_valid=0.
- out_ready  in  1  downstream accepts.
- Stall  in  1  hazard hold; freezes the stage.
- Flush  in  1  kill all held payloads (branch/jump redirect).
- stall_cnt  out  CNT_W  cycles with Stall=1 (optional feature only).
- flush_cnt  out  CNT_W  flush events (optional feature only).

Behaviour:
- Handshakes:
  - Upstream transfer: in_valid & in_ready.
  - Downstream transfer: out_valid & out_ready & !Stall.
- Storage: main register (out side) and skid register, each with a valid bit.
- States:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- Outputs:
  - in_ready = registered !skid_valid & !Stall_q, where Stall_q is Stall registered.
  - out_valid = main_valid.
  - out_data = main_data if main_valid, else BUBBLE_VAL.
- Transitions (Flush=0, Stall=0):
  - EMPTY + accept → FULL, data into main.
  - FULL + accept + drain → FULL, main replaced by in_data.
  - FULL + drain only → EMPTY.
  - FULL + accept only → SKID, data into skid.
  - SKID + drain → FULL, skid moves to main.
  - SKID never accepts, because in_ready=0.
- Latency: 1 cycle from accept to out_valid in EMPTY; throughput 1 per cycle when out_ready stays high.
- Stall=1:
  - No downstream transfer; main and skid hold.
  - A payload accepted in the same cycle, because in_ready was registered high, goes to main if EMPTY or to skid if FULL. No data is ever dropped.
  - in_ready drops the following cycle.
- Flush=1:
  - Highest priority, overrides Stall and any accept.
  - Next state EMPTY, both valid bits cleared, main_data and skid_data set to BUBBLE_VAL.
  - in_ready=1 the next cycle unless Stall is still high.
- Reset_n=0, asynchronous, any cycle including mid-transfer:
  - state EMPTY, out_valid=0, out_data=BUBBLE_VAL, in_ready=0, counters 0.
  - in_ready rises on the first clock edge after reset release.
- Simultaneous accept and drain in SKID cannot occur (in_ready=0).
- Payload ordering is strictly FIFO: skid data is never presented before older main data.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments every cycle with Stall=1.
  - flush_cnt increments every cycle with Flush=1.
  - Both saturate at all-ones, do not wrap, and clear only on Reset_n.
- Undefined:
  - Counter logic is absent and stall_cnt/flush_cnt are tied to 0.
  - Ports remain present, so the interface is identical in both builds.

Test Plan:
- Reset release, then in_valid=1 with data 0x0000_0004_2002_0001 and out_ready=1 → out_valid=1 with that data 1 cycle later; in_ready=1 throughout. Stream of 8 beats → 8 outputs in order, no gaps.
- out_ready=0, push A=0x11 then B=0x22 → state SKID, in_ready=0; raise out_ready → A then B on consecutive cycles, in_ready returns to 1.
- FULL with A, Stall=1 for 3 cycles with out_ready=1 → out_data stays A, no transfer; in_ready=0 from the 2nd cycle; Stall=0 → A drains.
- SKID state, Flush=1 together with Stall=1 and in_valid=1 → next cycle out_valid=0, out_data=BUBBLE_VAL (0), nothing retained.
- Reset_n pulsed low asynchronously mid-stream between edges → outputs go to reset values immediately, without waiting for Clk.
- With PIPE_STAGE_STATS_EN and CNT_W=4: 20 stall cycles → stall_cnt=15, saturated; 2 flush cycles → flush_cnt=2.
